// File: rtl/swarm_pkg.sv
// Shared task/slot types for the task dispatch path plus the arbiter state
// encoding and a small width helper.
package swarm;

    typedef logic [15:0] ts_t;

    typedef struct packed {
        ts_t         ts;
        logic [15:0] data;
    } task_t;

    typedef logic [7:0] cq_slice_slot_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT
    } arb_state_t;

    // Index width that stays legal (>= 1 bit) for a single-entry set.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/task_type_arbiter_if.sv
// FIFO-side and checker-side signals of the task-type arbiter.
// master = arbiter view, slave = FIFO/checker environment view.
interface task_type_arbiter_if #(
    parameter int N_TYPES = 4
) ();
    localparam int TYPE_W = swarm::idx_w(N_TYPES);

    logic [N_TYPES-1:0]    in_valid;
    swarm::task_t          in_task [N_TYPES];
    swarm::cq_slice_slot_t in_slot [N_TYPES];
    logic [N_TYPES-1:0]    in_resp_valid;
    logic                  in_resp;

    logic                  out_valid;
    logic                  out_ready;
    swarm::task_t          out_task;
    swarm::cq_slice_slot_t out_slot;
    logic [TYPE_W-1:0]     out_type;
    logic                  out_resp_valid;
    logic                  out_resp;

    modport master (
        input  in_valid, in_task, in_slot, out_ready, out_resp_valid, out_resp,
        output in_resp_valid, in_resp, out_valid, out_task, out_slot, out_type
    );

    modport slave (
        output in_valid, in_task, in_slot, out_ready, out_resp_valid, out_resp,
        input  in_resp_valid, in_resp, out_valid, out_task, out_slot, out_type
    );
endinterface

// File: rtl/task_type_arbiter_rr_pick.sv
// Combinational circular priority pick: first set bit of eligible at or
// after start, as both a one-hot select and an index.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] start,
    output logic [N-1:0] sel,
    output logic [W-1:0] idx,
    output logic         any
);

    int          pos;
    logic [W-1:0] pos_w;

    always_comb begin
        sel   = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        pos_w = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_w = W'(pos);
            if (!any && eligible[pos_w]) begin
                any        = 1'b1;
                sel[pos_w] = 1'b1;
                idx        = pos_w;
            end
        end
    end

endmodule

// File: rtl/task_type_arbiter.sv
// Shares one conflict-checker port among N_TYPES dequeue FIFOs with per-type
// reject backoff. Define ARB_MIN_TS_EN to grant the smallest-ts eligible head.
module task_type_arbiter
    import swarm::*;
#(
    parameter int N_TYPES        = 4,
    parameter int BACKOFF_CYCLES = 8,
    parameter int BACKOFF_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    task_type_arbiter_if.master bus,
    output logic                busy,
    output logic [31:0]         stat_dispatched,
    output logic [31:0]         stat_rejected,
    output logic                proto_err
);

    localparam int TYPE_W = idx_w(N_TYPES);

    arb_state_t          state_reg, state_next;
    logic [TYPE_W-1:0]   grant_reg, grant_next;
    logic [N_TYPES-1:0]  grant_oh_reg, grant_oh_next;
    logic [TYPE_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [31:0]         stat_dispatched_reg, stat_rejected_reg;
    logic                proto_err_reg;

    logic [N_TYPES-1:0]  eligible, pick_mask, pick_sel, load_backoff, resp_valid;
    logic [TYPE_W-1:0]   pick_idx;
    logic                pick_any, out_valid, resp_fire;
    logic                disp_inc, rej_inc, proto_set;

    assign resp_fire    = (state_reg == WAIT) && bus.out_resp_valid;
    assign load_backoff = grant_oh_reg & {N_TYPES{resp_fire & bus.out_resp}};

    // Per-type backoff; a reject load wins over the running decrement.
    genvar gi;
    for (gi = 0; gi < N_TYPES; gi++) begin : g_backoff
        logic [BACKOFF_W-1:0] cnt_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (load_backoff[gi]) begin
                cnt_reg <= BACKOFF_W'(BACKOFF_CYCLES);
            end else if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end

        assign eligible[gi] = bus.in_valid[gi] && (cnt_reg == '0);
    end

`ifdef ARB_MIN_TS_EN
    ts_t               min_ts;
    logic [TYPE_W-1:0] min_iw;

    always_comb begin
        min_ts = '1;
        min_iw = '0;
        for (int i = 0; i < N_TYPES; i++) begin
            min_iw = TYPE_W'(i);
            if (eligible[min_iw] && (bus.in_task[min_iw].ts < min_ts)) begin
                min_ts = bus.in_task[min_iw].ts;
            end
        end
    end

    // Only the heads tied at the minimum go on to the round-robin tie-break.
    for (gi = 0; gi < N_TYPES; gi++) begin : g_min_mask
        assign pick_mask[gi] = eligible[gi] && (bus.in_task[gi].ts == min_ts);
    end
`else
    assign pick_mask = eligible;
`endif

    rr_pick #(
        .N (N_TYPES),
        .W (TYPE_W)
    ) u_rr_pick (
        .eligible (pick_mask),
        .start    (rr_ptr_reg),
        .sel      (pick_sel),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_oh_next = grant_oh_reg;
        rr_ptr_next   = rr_ptr_reg;
        out_valid     = 1'b0;
        resp_valid    = '0;
        disp_inc      = 1'b0;
        rej_inc       = 1'b0;
        proto_set     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.out_resp_valid) begin
                    proto_set = 1'b1;
                end
                if (pick_any) begin
                    grant_next    = pick_idx;
                    grant_oh_next = pick_sel;
                    state_next    = OFFER;
                end
            end
            OFFER: begin
                if (bus.out_resp_valid) begin
                    proto_set = 1'b1;
                end
                // A FIFO withdrawing its offered head is a protocol violation.
                if (!bus.in_valid[grant_reg]) begin
                    proto_set  = 1'b1;
                    state_next = IDLE;
                end else begin
                    out_valid = 1'b1;
                    if (bus.out_ready) begin
                        disp_inc   = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.out_resp_valid) begin
                    resp_valid  = grant_oh_reg;
                    rej_inc     = bus.out_resp;
                    rr_ptr_next = (grant_reg == TYPE_W'(N_TYPES - 1)) ? '0 : grant_reg + 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            grant_reg           <= '0;
            grant_oh_reg        <= '0;
            rr_ptr_reg          <= '0;
            stat_dispatched_reg <= '0;
            stat_rejected_reg   <= '0;
            proto_err_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_oh_reg <= grant_oh_next;
            rr_ptr_reg   <= rr_ptr_next;
            if (disp_inc) begin
                stat_dispatched_reg <= stat_dispatched_reg + 32'd1;
            end
            if (rej_inc) begin
                stat_rejected_reg <= stat_rejected_reg + 32'd1;
            end
            if (proto_set) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

    assign bus.out_valid     = out_valid;
    assign bus.out_task      = bus.in_task[grant_reg];
    assign bus.out_slot      = bus.in_slot[grant_reg];
    assign bus.out_type      = grant_reg;
    assign bus.in_resp_valid = resp_valid;
    assign bus.in_resp       = resp_fire & bus.out_resp;

    assign busy            = (state_reg != IDLE);
    assign stat_dispatched = stat_dispatched_reg;
    assign stat_rejected   = stat_rejected_reg;
    assign proto_err       = proto_err_reg;

endmodule

// File: tb/tb_task_type_arbiter.sv
// Self-checking bench for task_type_arbiter: vector tables feed a scoreboard
// of expected grants/responses, plus hand sequences for backoff, errors, reset.
module tb_task_type_arbiter;
    import swarm::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy, proto_err;
    logic [31:0] stat_dispatched, stat_rejected;

    always #5 clk = ~clk;

    task_type_arbiter_if #(.N_TYPES(N)) bus ();

    task_type_arbiter #(
        .N_TYPES        (N),
        .BACKOFF_CYCLES (8),
        .BACKOFF_W      (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .busy            (busy),
        .stat_dispatched (stat_dispatched),
        .stat_rejected   (stat_rejected),
        .proto_err       (proto_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int typ;
        bit resp;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        bit         resp;
        int         lat;
        int         typ;
    } vec_t;

    exp_t           sb[$];
    task_t          head_task [N];
    cq_slice_slot_t head_slot [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_head(input int i, input ts_t ts);
        head_task[i]   = '{ts: ts, data: 16'hA000 + 16'(i)};
        head_slot[i]   = 8'h10 + 8'(i);
        bus.in_task[i] = head_task[i];
        bus.in_slot[i] = head_slot[i];
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        bus.in_valid       = '0;
        bus.out_ready      = 1'b0;
        bus.out_resp_valid = 1'b0;
        bus.out_resp       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One full offer/handshake/response; expectations come from the scoreboard.
    task automatic do_txn(input logic [3:0] mask, input int lat,
                          output int start_cyc, output int grant_cyc, output int resp_cyc);
        exp_t       e;
        bit         seen;
        logic [3:0] exp_oh;
        seen         = 1'b0;
        e            = '{typ: 0, resp: 1'b0};
        bus.in_valid = mask;
        start_cyc    = cyc;
        grant_cyc    = -1;
        resp_cyc     = -1;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        if (sb.size() > 0) e = sb.pop_front();
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no out_valid want type %0d", e.typ);
            return;
        end
        grant_cyc = cyc;
        chk("out_type", 64'(bus.out_type), 64'(e.typ));
        chk("out_task", 64'(bus.out_task), 64'(head_task[e.typ]));
        chk("out_slot", 64'(bus.out_slot), 64'(head_slot[e.typ]));
        chk("busy_offer", 64'(busy), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        chk("busy_wait", 64'(busy), 64'd1);
        chk("out_valid_wait", 64'(bus.out_valid), 64'd0);
        bus.out_resp_valid = 1'b1;
        bus.out_resp       = e.resp;
        #1;
        exp_oh = 4'b0001 << e.typ;
        chk("in_resp_valid", 64'(bus.in_resp_valid), 64'(exp_oh));
        chk("in_resp", 64'(bus.in_resp), 64'(e.resp));
        @(posedge clk);
        #1;
        bus.out_resp_valid = 1'b0;
        bus.out_resp       = 1'b0;
        resp_cyc           = cyc;
        $display("txn type=%0d resp=%0d grant_cyc=%0d resp_cyc=%0d", e.typ, e.resp, grant_cyc, resp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int s, g, r, r_rej;
        for (int i = 0; i < N; i++) set_head(i, 16'h0100 + 16'(i));

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_resp_valid", 64'(bus.in_resp_valid), 64'd0);
        chk("rst_stat_disp", 64'(stat_dispatched), 64'd0);
        chk("rst_stat_rej", 64'(stat_rejected), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);

        // Single type 2, accept 3 cycles after handshake
        @(posedge clk);
        #1;
        sb.push_back('{typ: 2, resp: 1'b0});
        do_txn(4'b0100, 3, s, g, r);
        bus.in_valid = '0;
        chk("latency", 64'(g - s), 64'd1);
        @(negedge clk);
        chk("t1_stat_disp", 64'(stat_dispatched), 64'd1);
        chk("t1_busy_after", 64'(busy), 64'd0);

`ifdef ARB_MIN_TS_EN
        begin
            vec_t mt_vec [5];
            do_reset();
            set_head(0, 16'd50);
            set_head(1, 16'd20);
            set_head(2, 16'd20);
            set_head(3, 16'd90);
            mt_vec = '{'{4'b0010, 1'b0, 1, 1}, '{4'b1111, 1'b0, 1, 2},
                       '{4'b1011, 1'b0, 2, 1}, '{4'b1001, 1'b0, 1, 0},
                       '{4'b1000, 1'b0, 1, 3}};
            for (int v = 0; v < 5; v++) begin
                sb.push_back('{typ: mt_vec[v].typ, resp: mt_vec[v].resp});
                do_txn(mt_vec[v].mask, mt_vec[v].lat, s, g, r);
            end
            bus.in_valid = '0;
            @(negedge clk);
            chk("mt_stat_disp", 64'(stat_dispatched), 64'd5);
            chk("mt_busy_end", 64'(busy), 64'd0);
            for (int i = 0; i < N; i++) set_head(i, 16'h0100 + 16'(i));
        end
`else
        begin
            vec_t rr_vec [11];
            do_reset();
            rr_vec = '{'{4'b1111, 1'b0, 1, 0}, '{4'b1111, 1'b0, 2, 1},
                       '{4'b1111, 1'b0, 1, 2}, '{4'b1111, 1'b0, 3, 3},
                       '{4'b1111, 1'b0, 1, 0}, '{4'b1010, 1'b0, 1, 1},
                       '{4'b1010, 1'b0, 2, 3}, '{4'b0001, 1'b0, 1, 0},
                       '{4'b1001, 1'b0, 1, 3}, '{4'b0110, 1'b0, 1, 1},
                       '{4'b0100, 1'b0, 3, 2}};
            for (int v = 0; v < 11; v++) begin
                sb.push_back('{typ: rr_vec[v].typ, resp: rr_vec[v].resp});
                do_txn(rr_vec[v].mask, rr_vec[v].lat, s, g, r);
            end
            bus.in_valid = '0;
            @(negedge clk);
            chk("rr_busy_end", 64'(busy), 64'd0);
            chk("rr_stat_disp", 64'(stat_dispatched), 64'd11);
            chk("rr_stat_rej", 64'(stat_rejected), 64'd0);
        end
`endif

        // Reject type 1 -> backoff; type 3 served meanwhile
        do_reset();
        sb.push_back('{typ: 1, resp: 1'b1});
        do_txn(4'b1010, 1, s, g, r_rej);
        sb.push_back('{typ: 3, resp: 1'b0});
        do_txn(4'b1010, 1, s, g, r);
        sb.push_back('{typ: 1, resp: 1'b0});
        do_txn(4'b0010, 1, s, g, r);
        bus.in_valid = '0;
        chk("backoff_gap", 64'(g - r_rej), 64'd9);
        @(negedge clk);
        chk("bo_stat_rej", 64'(stat_rejected), 64'd1);
        chk("bo_stat_disp", 64'(stat_dispatched), 64'd3);

        // Stray response while IDLE
        do_reset();
        @(negedge clk);
        bus.out_resp_valid = 1'b1;
        bus.out_resp       = 1'b1;
        #1;
        chk("idle_resp_route", 64'(bus.in_resp_valid), 64'd0);
        @(posedge clk);
        #1;
        bus.out_resp_valid = 1'b0;
        bus.out_resp       = 1'b0;
        @(negedge clk);
        chk("idle_proto_err", 64'(proto_err), 64'd1);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_stat_rej", 64'(stat_rejected), 64'd0);

        // FIFO drops its head while offered
        do_reset();
        bus.in_valid = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        chk("drop_offer_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = '0;
        #1;
        chk("drop_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("drop_proto_err", 64'(proto_err), 64'd1);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_stat_disp", 64'(stat_dispatched), 64'd0);

        // Reset while waiting for the checker
        do_reset();
        bus.in_valid = 4'b0001;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("wr_busy_wait", 64'(busy), 64'd1);
        chk("wr_stat_disp", 64'(stat_dispatched), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        bus.out_resp_valid = 1'b1;
        @(negedge clk);
        chk("wr_busy", 64'(busy), 64'd0);
        chk("wr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("wr_stat_disp0", 64'(stat_dispatched), 64'd0);
        chk("wr_in_resp_valid", 64'(bus.in_resp_valid), 64'd0);
        chk("wr_proto_err", 64'(proto_err), 64'd0);
        bus.out_resp_valid = 1'b0;
        bus.in_valid       = '0;
        rst                = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/task_type_arbiter.md
Name: task_type_arbiter

Overview:
- Shares one conflict-checker port among N_TYPES per-task-type dequeue FIFOs.
- Selects one eligible FIFO head and presents it to the conflict checker, holding the grant until the accept/reject response returns.
- Routes the response back to the granted FIFO, which then dequeues its head or re-enqueues it.
- Applies a per-type backoff after a reject, so a conflicting type does not starve the other types.

Parameters:
- N_TYPES, 4, number of task-type FIFOs arbitrated.
- BACKOFF_CYCLES, 8, cycles a type stays ineligible after a reject; 0 disables backoff.
- BACKOFF_W, 8, width of the backoff counters; BACKOFF_CYCLES must be < 2^BACKOFF_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  N_TYPES  FIFO head valid, one bit per type.
- in_task  in  N_TYPES x task_t  FIFO head task per type.
- in_slot  in  N_TYPES x cq_slice_slot_t  FIFO head slot per type.
- in_resp_valid  out  N_TYPES  one-hot response strobe to the FIFOs.
- in_resp  out  1  0 = accept, 1 = reject; meaningful only with in_resp_valid.
- out_valid  out  1  task offered to the checker.
- out_ready  in  1  checker accepts the offer.
- out_task  out  task_t  granted task.
- out_slot  out  cq_slice_slot_t  granted slot.
- out_type  out  clog2(N_TYPES)  granted type index.
- out_resp_valid  in  1  checker response strobe.
- out_resp  in  1  0 = accept, 1 = reject.
- busy  out  1  state != IDLE, used for termination checking.
- stat_dispatched  out  32  count of tasks accepted by out_ready; wraps.
- stat_rejected  out  32  count of reject responses; wraps.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset values: state IDLE; out_valid 0; in_resp_valid all 0; grant 0; rr_ptr 0; backoff counters 0; stats 0; proto_err 0.
- Eligible type i: in_valid[i] and backoff[i] == 0.
- IDLE:
  - If any type is eligible, register grant = first eligible type at or after rr_ptr (circular).
  - Next state OFFER. Latency from in_valid to out_valid is 1 cycle.
- OFFER:
  - out_valid = 1; out_task, out_slot and out_type are muxed from the registered grant.
  - On out_valid & out_ready: increment stat_dispatched and go to WAIT.
  - If in_valid[grant] drops: set proto_err, deassert out_valid, return to IDLE.
- WAIT:
  - out_valid = 0.
  - On out_resp_valid, in the same cycle: in_resp_valid[grant] = 1 and in_resp = out_resp.
  - Then rr_ptr <= (grant + 1) mod N_TYPES and next state IDLE.
  - If out_resp = 1: stat_rejected++ and backoff[grant] <= BACKOFF_CYCLES.
- out_resp_valid in IDLE or OFFER is ignored, sets proto_err, and produces no in_resp_valid pulse.
- A response may arrive at the earliest 1 cycle after the out_ready handshake. A response in the handshake cycle is a protocol error.
- Backoff counters:
  - Each nonzero counter decrements by 1 every cycle.
  - A load on reject takes priority over the decrement.
  - Counters run regardless of state.
- Exactly one task is outstanding at a time. Peak throughput is one task per (3 + checker latency) cycles.
- If every valid type is in backoff, remain in IDLE. No grant is issued to a type that is not eligible.
- Reset mid-operation returns to IDLE immediately. No in_resp_valid pulse is generated for the dropped task; the FIFO head is retained by the FIFO itself.
- Counters wrap at 2^32 without saturation.
- N_TYPES = 1: rr_ptr stays 0 and behaviour is otherwise identical.

Optional Feature:
- Macro ARB_MIN_TS_EN defined: IDLE grants the eligible type whose in_task.ts is smallest (unsigned compare). Ties go to the first tied type at or after rr_ptr. The compare tree may be registered only if the 1-cycle grant latency is preserved.
- Macro undefined: pure round-robin as above. in_task.ts is not used for selection.

Decomposition:
- Package swarm: task_t, cq_slice_slot_t and ts_t already exist.
- Package swarm: add arb_state_t enum (IDLE, OFFER, WAIT).
- One sub-module, rr_pick: parameter N; inputs eligible mask and start pointer; outputs one-hot select and index. It is purely combinational and is reused by the min-ts tie-break path.

Test Plan:
- Only type 2 valid, out_ready = 1, accept response 3 cycles after handshake -> out_valid 1 cycle after in_valid with out_type 2; in_resp_valid = 4'b0100 with in_resp 0 in the response cycle; stat_dispatched = 1.
- All 4 types valid, checker always accepts -> grant sequence 0,1,2,3,0; one in_resp_valid pulse per grant; busy drops only after the final response.
- Type 1 rejected, BACKOFF_CYCLES = 8, types 1 and 3 valid -> type 1 is not regranted within 8 cycles after the reject; type 3 is granted meanwhile; stat_rejected = 1.
- out_resp_valid pulsed while IDLE -> proto_err = 1, no in_resp_valid pulse, state unchanged.
- rst asserted in WAIT -> next cycle: state IDLE, out_valid 0, stats 0, no response routed.
- ARB_MIN_TS_EN, heads ts = {50, 20, 20, 90}, rr_ptr = 2 -> type 2 granted, then type 1, then 0, then 3.
